// File: rtl/shift_sequencer_if.sv
// Word handshake, shift-register control and serial output bundle.
interface shift_sequencer_if;
  logic [3:0] word_in;
  logic       word_valid_in;
  logic       word_ready_out;
  logic       flush_in;
  logic [3:0] sr_parallel_out;
  logic       sr_load_out;
  logic       sr_shift_out;
  logic       sr_fill_out;
  logic       sr_bit_in;
  logic       ser_data_out;
  logic       ser_valid_out;
  logic       ser_first_out;

  modport master (
    output word_in, word_valid_in, flush_in, sr_bit_in,
    input  word_ready_out, sr_parallel_out, sr_load_out,
    input  sr_shift_out, sr_fill_out,
    input  ser_data_out, ser_valid_out, ser_first_out
  );

  modport slave (
    input  word_in, word_valid_in, flush_in, sr_bit_in,
    output word_ready_out, sr_parallel_out, sr_load_out,
    output sr_shift_out, sr_fill_out,
    output ser_data_out, ser_valid_out, ser_first_out
  );
endinterface

// File: rtl/shift_sequencer.sv
// Sequences an external 4-bit shift register into a serial stream.
// Define SHIFT_SEQUENCER_PARITY_EN to append an even-parity bit period.
module shift_sequencer #(
  parameter int unsigned DIV  = 1,
  parameter logic        FILL = 1'b0
) (
  input logic             clk_in,
  input logic             rst_in,
  shift_sequencer_if.slave bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

`ifdef SHIFT_SEQUENCER_PARITY_EN
  typedef enum logic [1:0] {IDLE, LOAD, BIT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, BIT} state_t;
`endif

  state_t        state, state_nxt;
  logic [PW-1:0] per_cnt, per_nxt;
  logic [1:0]    bit_cnt, bit_nxt;
  logic [3:0]    word_q;
  logic          ready, take, per_end;

  // flush wins over a transfer, so it also withdraws ready
  assign ready   = (state == IDLE) && !rst_in && !bus.flush_in;
  assign take    = bus.word_valid_in && ready;
  assign per_end = (per_cnt == LAST);

  assign bus.word_ready_out  = ready;
  assign bus.sr_parallel_out = word_q;
  assign bus.sr_fill_out     = FILL;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= IDLE;
      per_cnt <= '0;
      bit_cnt <= '0;
      word_q  <= '0;
    end else begin
      state   <= state_nxt;
      per_cnt <= per_nxt;
      bit_cnt <= bit_nxt;
      if (take) word_q <= bus.word_in;
    end
  end

  always_comb begin
    state_nxt         = state;
    per_nxt           = per_cnt;
    bit_nxt           = bit_cnt;
    bus.sr_load_out   = 1'b0;
    bus.sr_shift_out  = 1'b0;
    bus.ser_valid_out = 1'b0;
    bus.ser_data_out  = 1'b0;
    bus.ser_first_out = 1'b0;
    unique case (state)
      IDLE: begin
        per_nxt = '0;
        bit_nxt = '0;
        if (take) state_nxt = LOAD;
      end
      LOAD: begin
        bus.sr_load_out = 1'b1;
        state_nxt       = BIT;
      end
      BIT: begin
        bus.ser_valid_out = 1'b1;
        bus.ser_data_out  = bus.sr_bit_in;
        bus.ser_first_out = (bit_cnt == 2'd0);
        bus.sr_shift_out  = per_end;
        per_nxt = per_end ? '0 : per_cnt + 1'b1;
        if (per_end) begin
          bit_nxt = bit_cnt + 2'd1;
          if (bit_cnt == 2'd3) begin
`ifdef SHIFT_SEQUENCER_PARITY_EN
            state_nxt = PAR;
`else
            state_nxt = IDLE;
`endif
          end
        end
      end
`ifdef SHIFT_SEQUENCER_PARITY_EN
      PAR: begin
        bus.ser_valid_out = 1'b1;
        bus.ser_data_out  = ^word_q;
        per_nxt = per_end ? '0 : per_cnt + 1'b1;
        if (per_end) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
    if (bus.flush_in) begin
      state_nxt        = IDLE;
      per_nxt          = '0;
      bit_nxt          = '0;
      bus.sr_load_out  = 1'b0;
      bus.sr_shift_out = 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: DIV=1 and DIV=3 sequencers with shift-register models.
module tb_shift_sequencer;

  typedef struct packed {
    logic       ready;
    logic       load;
    logic       shift;
    logic       valid;
    logic       data;
    logic       first;
    logic [3:0] par;
  } exp_t;

  typedef struct packed {
    logic [3:0] word;
    logic [3:0] bits;
    logic       par;
  } vec_t;

`ifdef SHIFT_SEQUENCER_PARITY_EN
  localparam int PLEN = 1;
`else
  localparam int PLEN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  shift_sequencer_if b1 ();
  shift_sequencer_if b3 ();

  shift_sequencer #(.DIV(1), .FILL(1'b0)) dut1 (
    .clk_in(clk), .rst_in(rst), .bus(b1)
  );
  shift_sequencer #(.DIV(3), .FILL(1'b1)) dut3 (
    .clk_in(clk), .rst_in(rst), .bus(b3)
  );

  logic [3:0] sr1 = 4'h0;
  logic [3:0] sr3 = 4'h0;

  always @(posedge clk) begin
    if (b1.sr_load_out) sr1 <= b1.sr_parallel_out;
    else if (b1.sr_shift_out) sr1 <= {b1.sr_fill_out, sr1[3:1]};
    if (b3.sr_load_out) sr3 <= b3.sr_parallel_out;
    else if (b3.sr_shift_out) sr3 <= {b3.sr_fill_out, sr3[3:1]};
  end

  assign b1.sr_bit_in = sr1[0];
  assign b3.sr_bit_in = sr3[0];

  // Reference: each accepted word becomes a list of per-cycle expectations
  exp_t q1[$];
  exp_t q3[$];
  exp_t tmp[$];
  logic [3:0] lw1 = 4'h0;
  logic [3:0] lw3 = 4'h0;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void build(input int div, input logic [3:0] w);
    exp_t r;
    tmp.delete();
    r = '0;
    r.load = 1'b1;
    r.par = w;
    tmp.push_back(r);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < div; k++) begin
        r = '0;
        r.valid = 1'b1;
        r.data = w[i];
        r.shift = (k == div - 1);
        r.first = (i == 0);
        r.par = w;
        tmp.push_back(r);
      end
    for (int p = 0; p < PLEN * div; p++) begin
      r = '0;
      r.valid = 1'b1;
      r.data = ^w;
      r.par = w;
      tmp.push_back(r);
    end
  endfunction

  function automatic exp_t predict(input int sel, input logic f,
                                   input logic r);
    exp_t e;
    e = '0;
    if (!r) begin
      if (sel == 1 && q1.size() != 0) e = q1[0];
      else if (sel == 3 && q3.size() != 0) e = q3[0];
      else begin
        e.ready = 1'b1;
        e.par = (sel == 1) ? lw1 : lw3;
      end
      if (f) begin
        e.ready = 1'b0;
        e.load = 1'b0;
        e.shift = 1'b0;
      end
    end
    return e;
  endfunction

  function automatic void advance(input int sel, input logic v,
                                  input logic [3:0] w, input logic f,
                                  input logic r);
    if (sel == 1) begin
      if (r) begin q1.delete(); lw1 = 4'h0; end
      else if (f) q1.delete();
      else if (q1.size() != 0) void'(q1.pop_front());
      else if (v) begin
        lw1 = w;
        build(1, w);
        foreach (tmp[i]) q1.push_back(tmp[i]);
      end
    end else begin
      if (r) begin q3.delete(); lw3 = 4'h0; end
      else if (f) q3.delete();
      else if (q3.size() != 0) void'(q3.pop_front());
      else if (v) begin
        lw3 = w;
        build(3, w);
        foreach (tmp[i]) q3.push_back(tmp[i]);
      end
    end
  endfunction

  function automatic exp_t actual(input int sel);
    exp_t a;
    if (sel == 1)
      a = {b1.word_ready_out, b1.sr_load_out, b1.sr_shift_out,
           b1.ser_valid_out, b1.ser_data_out, b1.ser_first_out,
           b1.sr_parallel_out};
    else
      a = {b3.word_ready_out, b3.sr_load_out, b3.sr_shift_out,
           b3.ser_valid_out, b3.ser_data_out, b3.ser_first_out,
           b3.sr_parallel_out};
    return a;
  endfunction

  // One cycle: drive after the falling edge, compare 1ns later
  task automatic step(input logic v, input logic [3:0] w, input logic f,
                      input logic r);
    @(negedge clk);
    rst = r;
    b1.word_valid_in = v; b1.word_in = w; b1.flush_in = f;
    b3.word_valid_in = v; b3.word_in = w; b3.flush_in = f;
    #1;
    chk("model_div1", 16'(actual(1)), 16'(predict(1, f, r)));
    chk("model_div3", 16'(actual(3)), 16'(predict(3, f, r)));
    advance(1, v, w, f, r);
    advance(3, v, w, f, r);
  endtask

  task automatic wait_idle(input int sel);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      step(1'b0, 4'h0, 1'b0, 1'b0);
      ok = (sel == 1) ? b1.word_ready_out : b3.word_ready_out;
    end
    chk("idle_wait", 16'(ok), 16'd1);
  endtask

  task automatic send1(input vec_t t);
    wait_idle(1);
    step(1'b1, t.word, 1'b0, 1'b0);
    chk("xfer_ready", 16'(b1.word_ready_out), 16'd1);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("load", 16'({b1.sr_load_out, b1.sr_parallel_out}),
        16'({1'b1, t.word}));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'h0, 1'b0, 1'b0);
      chk($sformatf("bit%0d", i),
          16'({b1.ser_valid_out, b1.ser_data_out, b1.sr_shift_out,
               b1.ser_first_out}),
          16'({1'b1, t.bits[i], 1'b1, i == 0}));
    end
    for (int p = 0; p < PLEN; p++) begin
      step(1'b0, 4'h0, 1'b0, 1'b0);
      chk("parity",
          16'({b1.ser_valid_out, b1.ser_data_out, b1.sr_shift_out}),
          16'({1'b1, t.par, 1'b0}));
    end
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("end_ready", 16'({b1.word_ready_out, b1.ser_valid_out}),
        16'({1'b1, 1'b0}));
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{word: 4'b1011, bits: 4'b1011, par: 1'b1};
    vecs[1] = '{word: 4'b0011, bits: 4'b0011, par: 1'b0};
    vecs[2] = '{word: 4'b0110, bits: 4'b0110, par: 1'b0};
    vecs[3] = '{word: 4'b1111, bits: 4'b1111, par: 1'b0};
    vecs[4] = '{word: 4'b0001, bits: 4'b0001, par: 1'b1};
    vecs[5] = '{word: 4'b1000, bits: 4'b1000, par: 1'b1};

    b1.word_valid_in = 1'b0; b1.word_in = 4'h0; b1.flush_in = 1'b0;
    b3.word_valid_in = 1'b0; b3.word_in = 4'h0; b3.flush_in = 1'b0;

    step(1'b1, 4'hf, 1'b0, 1'b1);
    chk("rst_outputs",
        16'({b1.word_ready_out, b1.sr_load_out, b1.ser_valid_out,
             b1.sr_parallel_out}), 16'd0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("ready_after_rst", 16'(b1.word_ready_out), 16'd1);
    chk("fill", 16'({b1.sr_fill_out, b3.sr_fill_out}), 16'b01);

    foreach (vecs[i]) send1(vecs[i]);

    // DIV=3: each bit held three cycles, shift on the third
    wait_idle(3);
    step(1'b1, 4'b0110, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("div3_load", 16'(b3.sr_load_out), 16'd1);
    for (int c = 0; c < 12; c++) begin
      logic [3:0] wv;
      wv = 4'b0110;
      step(1'b0, 4'h0, 1'b0, 1'b0);
      chk($sformatf("div3_c%0d", c),
          16'({b3.ser_data_out, b3.sr_shift_out, b3.ser_first_out}),
          16'({wv[c / 3], c % 3 == 2, c < 3}));
    end

    // flush two cycles into a word
    wait_idle(1);
    step(1'b1, 4'b1011, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("flush_strobes", 16'({b1.sr_shift_out, b1.sr_load_out}), 16'd0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("flush_idle", 16'({b1.word_ready_out, b1.ser_valid_out}),
        16'b10);
    send1(vecs[1]);

    // reset pulse mid-word
    wait_idle(1);
    step(1'b1, 4'b1011, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    chk("rst_async",
        16'({b1.word_ready_out, b1.sr_load_out, b1.sr_shift_out,
             b1.ser_valid_out, b1.ser_data_out, b1.ser_first_out,
             b1.sr_parallel_out}), 16'd0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("rst_release", 16'(b1.word_ready_out), 16'd1);
    send1(vecs[3]);

    // valid held high: second word waits for IDLE
    wait_idle(1);
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    for (int c = 1; c <= 2 + 4 + PLEN; c++) begin
      step(1'b1, 4'b1000, 1'b0, 1'b0);
      chk($sformatf("b2b_ready_c%0d", c), 16'(b1.word_ready_out),
          16'(c == 2 + 4 + PLEN));
    end
    step(1'b1, 4'b1000, 1'b0, 1'b0);
    chk("b2b_load", 16'({b1.sr_load_out, b1.sr_parallel_out}),
        16'({1'b1, 4'b1000}));
    for (int c = 0; c < 8; c++) step(1'b0, 4'h0, 1'b0, 1'b0);

    for (int n = 0; n < 800; n++)
      step(1'($urandom_range(0, 1)), 4'($urandom),
           1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 96) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
